// File: rtl/test_sched_if.sv
// Scheduler <-> test-unit bundle: start request, per-unit flags and resets, sequence status.
interface test_sched_if #(
    parameter int N = 6
);
    logic         start;
    logic [N-1:0] test_fail;
    logic [N-1:0] test_finish;
    logic [N-1:0] test_reset;
    logic         busy;
    logic [3:0]   cur;
    logic [N-1:0] fail_mask;
    logic [N-1:0] tmo_mask;
    logic         done;
    logic         pass;

    modport master (
        input  start, test_fail, test_finish,
        output test_reset, busy, cur, fail_mask, tmo_mask, done, pass
    );

    modport slave (
        output start, test_fail, test_finish,
        input  test_reset, busy, cur, fail_mask, tmo_mask, done, pass
    );
endinterface

// File: rtl/test_sched.sv
// Sequences N test units one at a time, recording per-unit fail/timeout results.
// Optional per-test RUN timeout is enabled by defining TEST_SCHED_TIMEOUT_EN.
module test_sched #(
    parameter int N            = 6,
    parameter int TIMEOUT      = 1024,
    parameter int GAP          = 2,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic          clock,
    input  logic          reset,
    test_sched_if.master  bus
);
`ifdef TEST_SCHED_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [3:0]  CUR_LAST = 4'(N - 1);
    localparam logic [3:0]  GAP_LAST = 4'(GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RELEASE,
        ST_RUN,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   cur_q, cur_d;
    logic [N-1:0] fail_q, fail_d;
    logic [N-1:0] tmo_q, tmo_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [3:0]   gap_q, gap_d;

    logic [N-1:0] cur_sel;
    logic         sel_fail;
    logic         sel_fin;

    // One-hot of the current unit; flags from every other unit are masked off.
    always_comb begin
        cur_sel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cur_q == 4'(i)) cur_sel[i] = 1'b1;
        end
    end

    assign sel_fail = |(bus.test_fail & cur_sel);
    assign sel_fin  = |(bus.test_finish & cur_sel);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            fail_q  <= '0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            fail_q  <= fail_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        fail_d  = fail_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    cur_d   = '0;
                    fail_d  = '0;
                    tmo_d   = '0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
                gap_d = '0;
                if (sel_fail) begin
                    fail_d  = fail_q | cur_sel;
                    state_d = ST_GAP;
                end else if (sel_fin) begin
                    state_d = ST_GAP;
                end else if (TMO_EN && cnt_q == TMO_LAST) begin
                    fail_d  = fail_q | cur_sel;
                    tmo_d   = tmo_q | cur_sel;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (cur_q == CUR_LAST || (STOP_ON_FAIL != 0 && |fail_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_d   = cur_q + 4'd1;
                        state_d = ST_RELEASE;
                    end
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.test_reset = '1;
        if (state_q == ST_RELEASE || state_q == ST_RUN) bus.test_reset = ~cur_sel;
    end

    assign bus.busy      = (state_q == ST_RELEASE) || (state_q == ST_RUN) || (state_q == ST_GAP);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.pass      = (state_q == ST_DONE) && (fail_q == '0);
    assign bus.cur       = cur_q;
    assign bus.fail_mask = fail_q;
    assign bus.tmo_mask  = tmo_q;
endmodule
